// File: rtl/eeg_sample_buffer.sv
// EEG ingest buffer: captures ADC samples in a small FIFO and meters them out to the
// master one pulse per pop, counting samples per sleep epoch.
module eeg_sample_buffer #(
  parameter int EEG_SAMPLE_DEPTH  = 16,
  parameter int FIFO_DEPTH        = 8,
  parameter int SAMPLES_PER_EPOCH = 3000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          new_sleep_epoch,
  input  logic                          adc_valid,
  input  logic [EEG_SAMPLE_DEPTH-1:0]   adc_sample,
  input  logic                          master_ready,
  output logic                          new_eeg_sample,
  output logic [EEG_SAMPLE_DEPTH-1:0]   eeg_sample,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          epoch_done
);

  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = PW + 1;
  localparam int EW   = $clog2(SAMPLES_PER_EPOCH + 1);

  localparam logic [CNTW-1:0] FULL_LVL  = CNTW'(FIFO_DEPTH);
  localparam logic [EW-1:0]   EPOCH_MAX = EW'(SAMPLES_PER_EPOCH);
  localparam logic [EW-1:0]   EPOCH_LST = EW'(SAMPLES_PER_EPOCH - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DRAIN   = 2'd2
  } state_e;

  state_e                      state_q, state_d;
  logic [EEG_SAMPLE_DEPTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]               wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]               rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]             count_q, count_d;
  logic [EW-1:0]               accepted_q, accepted_d;
  logic [EW-1:0]               sent_q, sent_d;
  logic                        overflow_q, overflow_d;
  logic                        new_sample_q, new_sample_d;
  logic [EEG_SAMPLE_DEPTH-1:0] sample_q, sample_d;
  logic                        epoch_done_q, epoch_done_d;

  logic full_s;
  logic pop_en_s;
  logic push_req_s;
  logic push_s;
  logic pop_s;
  logic drop_s;

  assign full_s     = (count_q == FULL_LVL);
  assign pop_en_s   = (state_q != S_IDLE) && master_ready && (count_q != {CNTW{1'b0}});
  assign push_req_s = (state_q == S_COLLECT) && adc_valid && (accepted_q < EPOCH_MAX);

  // Next-state logic: a new epoch request overrides every push and pop in its cycle.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    accepted_d   = accepted_q;
    sent_d       = sent_q;
    overflow_d   = overflow_q;
    sample_d     = sample_q;
    new_sample_d = 1'b0;
    epoch_done_d = 1'b0;
    push_s       = 1'b0;
    pop_s        = 1'b0;
    drop_s       = 1'b0;

    if (new_sleep_epoch) begin
      wr_ptr_d   = {PW{1'b0}};
      rd_ptr_d   = {PW{1'b0}};
      count_d    = {CNTW{1'b0}};
      accepted_d = {EW{1'b0}};
      sent_d     = {EW{1'b0}};
      overflow_d = 1'b0;
      state_d    = S_COLLECT;
    end else begin
      pop_s  = pop_en_s;
      push_s = push_req_s && (!full_s || pop_en_s);
      drop_s = push_req_s && full_s && !pop_en_s;

      if (pop_s) begin
        sample_d     = mem_q[rd_ptr_q];
        new_sample_d = 1'b1;
        rd_ptr_d     = rd_ptr_q + PW'(1);
        if (sent_q < EPOCH_MAX) begin
          sent_d = sent_q + EW'(1);
        end else begin
          sent_d = sent_q;
        end
        if (sent_q == EPOCH_LST) begin
          epoch_done_d = 1'b1;
        end else begin
          epoch_done_d = 1'b0;
        end
      end else begin
        rd_ptr_d = rd_ptr_q;
      end

      if (push_s) begin
        wr_ptr_d   = wr_ptr_q + PW'(1);
        accepted_d = accepted_q + EW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end

      // Push with a simultaneous pop leaves occupancy unchanged, even when full.
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNTW'(1);
        2'b01:   count_d = count_q - CNTW'(1);
        default: count_d = count_q;
      endcase

      if (drop_s) begin
        overflow_d = 1'b1;
      end else begin
        overflow_d = overflow_q;
      end

      case (state_q)
        S_IDLE:    state_d = S_IDLE;
        S_COLLECT: begin
          if (push_s && (accepted_q == EPOCH_LST)) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_COLLECT;
          end
        end
        S_DRAIN: begin
          if (pop_s && (sent_q == EPOCH_LST)) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DRAIN;
          end
        end
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= {PW{1'b0}};
      rd_ptr_q     <= {PW{1'b0}};
      count_q      <= {CNTW{1'b0}};
      accepted_q   <= {EW{1'b0}};
      sent_q       <= {EW{1'b0}};
      overflow_q   <= 1'b0;
      new_sample_q <= 1'b0;
      sample_q     <= {EEG_SAMPLE_DEPTH{1'b0}};
      epoch_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      accepted_q   <= accepted_d;
      sent_q       <= sent_d;
      overflow_q   <= overflow_d;
      new_sample_q <= new_sample_d;
      sample_q     <= sample_d;
      epoch_done_q <= epoch_done_d;
    end
  end

  // Storage array; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (!rst && push_s) begin
      mem_q[wr_ptr_q] <= adc_sample;
    end
  end

  assign new_eeg_sample = new_sample_q;
  assign eeg_sample     = sample_q;
  assign fifo_count     = count_q;
  assign overflow       = overflow_q;
  assign epoch_done     = epoch_done_q;

endmodule

// File: tb/tb_eeg_sample_buffer.sv
// Scoreboard bench for eeg_sample_buffer: one full-size instance and one with a 4-sample epoch.
module tb_eeg_sample_buffer;

  logic        clk;
  logic        rst;

  logic        nse_a, valid_a, ready_a;
  logic [15:0] adc_a;
  logic        nes_a, ovf_a, done_a;
  logic [15:0] smp_a;
  logic [3:0]  cnt_a;

  logic        nse_b, valid_b, ready_b;
  logic [15:0] adc_b;
  logic        nes_b, ovf_b, done_b;
  logic [15:0] smp_b;
  logic [3:0]  cnt_b;

  int checks;
  int fails;
  int pulses_b;

  logic [15:0] exp_a[$];
  logic [16:0] exp_b[$];

  eeg_sample_buffer #(.EEG_SAMPLE_DEPTH(16), .FIFO_DEPTH(8), .SAMPLES_PER_EPOCH(3000)) dut_a (
    .clk(clk), .rst(rst), .new_sleep_epoch(nse_a), .adc_valid(valid_a), .adc_sample(adc_a),
    .master_ready(ready_a), .new_eeg_sample(nes_a), .eeg_sample(smp_a), .fifo_count(cnt_a),
    .overflow(ovf_a), .epoch_done(done_a)
  );

  eeg_sample_buffer #(.EEG_SAMPLE_DEPTH(16), .FIFO_DEPTH(8), .SAMPLES_PER_EPOCH(4)) dut_b (
    .clk(clk), .rst(rst), .new_sleep_epoch(nse_b), .adc_valid(valid_b), .adc_sample(adc_b),
    .master_ready(ready_b), .new_eeg_sample(nes_b), .eeg_sample(smp_b), .fifo_count(cnt_b),
    .overflow(ovf_b), .epoch_done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor for the full-size instance: every pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (nes_a) begin
      checks++;
      if (exp_a.size() == 0) begin
        fails++;
        $display("FAIL a_unexpected_pulse: got 0x%0h, expected no pulse", smp_a);
      end else begin
        logic [15:0] e;
        e = exp_a.pop_front();
        if (smp_a !== e) begin
          fails++;
          $display("FAIL a_sample: got 0x%0h, expected 0x%0h", smp_a, e);
        end
      end
    end
    if (done_a) begin
      checks++;
      fails++;
      $display("FAIL a_epoch_done: got 1, expected 0");
    end
  end

  // Monitor for the short-epoch instance: checks sample and epoch_done together.
  always @(negedge clk) begin
    if (nes_b) begin
      pulses_b++;
      checks++;
      if (exp_b.size() == 0) begin
        fails++;
        $display("FAIL b_unexpected_pulse: got 0x%0h, expected no pulse", smp_b);
      end else begin
        logic [16:0] e;
        e = exp_b.pop_front();
        if ({done_b, smp_b} !== e) begin
          fails++;
          $display("FAIL b_sample: got done=%0b 0x%0h, expected done=%0b 0x%0h",
                   done_b, smp_b, e[16], e[15:0]);
        end
      end
    end else if (done_b) begin
      checks++;
      fails++;
      $display("FAIL b_stray_epoch_done: got 1 without pulse, expected 0");
    end
  end

  initial begin
    checks   = 0;
    fails    = 0;
    pulses_b = 0;
    rst = 1'b1;
    nse_a = 1'b0; valid_a = 1'b0; ready_a = 1'b0; adc_a = 16'h0000;
    nse_b = 1'b0; valid_b = 1'b0; ready_b = 1'b0; adc_b = 16'h0000;

    // 1: reset, then a sample in IDLE is ignored
    repeat (2) tick();
    rst = 1'b0;
    valid_a = 1'b1; adc_a = 16'h1234; ready_a = 1'b1;
    tick();
    valid_a = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("idle_count", cnt_a, 0);
    chk("idle_pulse", nes_a, 0);
    chk("idle_sample", smp_a, 0);
    chk("idle_overflow", ovf_a, 0);
    chk("idle_done", done_a, 0);
    chk("idle_count_b", cnt_b, 0);

    // 2: single sample, two-cycle latency
    tick();
    nse_a = 1'b1;
    tick();
    nse_a = 1'b0;
    valid_a = 1'b1; adc_a = 16'h0001; ready_a = 1'b1;
    exp_a.push_back(16'h0001);
    tick();
    valid_a = 1'b0;
    @(negedge clk);
    chk("lat_count_t1", cnt_a, 1);
    chk("lat_pulse_t1", nes_a, 0);
    tick();
    @(negedge clk);
    chk("lat_pulse_t2", nes_a, 1);
    chk("lat_count_t2", cnt_a, 0);
    tick();

    // 3: nine samples into an eight-deep FIFO
    ready_a = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      valid_a = 1'b1; adc_a = 16'(i);
      if (i <= 8) exp_a.push_back(16'(i));
      tick();
    end
    valid_a = 1'b0;
    @(negedge clk);
    chk("ovf_count", cnt_a, 8);
    chk("ovf_flag", ovf_a, 1);
    tick();
    ready_a = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      @(negedge clk);
      chk("burst_pulse", nes_a, 1);
    end
    ready_a = 1'b0;
    tick();
    @(negedge clk);
    chk("burst_end_pulse", nes_a, 0);
    chk("burst_end_count", cnt_a, 0);
    chk("burst_ovf_sticky", ovf_a, 1);

    // 4: full FIFO with simultaneous push and pop
    tick();
    nse_a = 1'b1;
    tick();
    nse_a = 1'b0;
    for (int i = 0; i < 8; i++) begin
      valid_a = 1'b1; adc_a = 16'h0040 + 16'(i);
      exp_a.push_back(16'h0040 + 16'(i));
      tick();
    end
    valid_a = 1'b0;
    @(negedge clk);
    chk("full_count", cnt_a, 8);
    chk("full_ovf_clear", ovf_a, 0);
    tick();
    valid_a = 1'b1; adc_a = 16'h0048; ready_a = 1'b1;
    exp_a.push_back(16'h0048);
    tick();
    valid_a = 1'b0; ready_a = 1'b0;
    @(negedge clk);
    chk("pushpop_count", cnt_a, 8);
    chk("pushpop_ovf", ovf_a, 0);
    chk("pushpop_pulse", nes_a, 1);
    tick();
    ready_a = 1'b1;
    repeat (8) tick();
    ready_a = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    chk("pushpop_drained", cnt_a, 0);

    // 6: new epoch with five entries and overflow set
    tick();
    for (int i = 0; i < 9; i++) begin
      valid_a = 1'b1; adc_a = 16'h0050 + 16'(i);
      if (i < 3) exp_a.push_back(16'h0050 + 16'(i));
      tick();
    end
    valid_a = 1'b0; ready_a = 1'b1;
    repeat (3) tick();
    ready_a = 1'b0;
    @(negedge clk);
    chk("pre_flush_count", cnt_a, 5);
    chk("pre_flush_ovf", ovf_a, 1);
    tick();
    nse_a = 1'b1; ready_a = 1'b1; valid_a = 1'b1; adc_a = 16'h9999;
    tick();
    nse_a = 1'b0; ready_a = 1'b0; valid_a = 1'b0;
    @(negedge clk);
    chk("flush_count", cnt_a, 0);
    chk("flush_ovf", ovf_a, 0);
    tick();
    valid_a = 1'b1; adc_a = 16'hABCD; ready_a = 1'b1;
    exp_a.push_back(16'hABCD);
    tick();
    valid_a = 1'b0;
    repeat (4) tick();

    // 5: four-sample epoch, six samples offered
    nse_b = 1'b1;
    tick();
    nse_b = 1'b0; ready_b = 1'b1;
    for (int i = 0; i < 6; i++) begin
      valid_b = 1'b1; adc_b = 16'h0061 + 16'(i);
      if (i < 4) exp_b.push_back({(i == 3), 16'h0061 + 16'(i)});
      tick();
    end
    valid_b = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    chk("epoch_pulses", pulses_b, 4);
    chk("epoch_count", cnt_b, 0);
    chk("epoch_ovf", ovf_b, 0);
    tick();
    valid_b = 1'b1; adc_b = 16'h0077;
    tick();
    valid_b = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    chk("post_epoch_idle_count", cnt_b, 0);
    chk("post_epoch_pulses", pulses_b, 4);

    chk("a_missing_outputs", exp_a.size(), 0);
    chk("b_missing_outputs", exp_b.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
